// File: rtl/ram_arbiter.sv
// ram_arbiter: one single-port RAM of 2^ADDR_W words shared by PORTS
// requesters. Requesters use a valid/ready handshake, and a round-robin
// arbiter grants at most one access per cycle. Reads return on a shared data
// bus, with a per-port strobe, RD_LAT cycles after the handshake. A bulk-clear
// mode zeroes the whole memory, one word per cycle.
//
// Ports:
//   clk_i, rst_ni    clock (rising edge) and asynchronous active-low reset
//   req_valid_i      per-port request present
//   req_write_i      per-port 1 = write, 0 = read
//   req_addr_i       port p address at [p*ADDR_W +: ADDR_W]
//   req_data_i       port p write data at [p*DATA_W +: DATA_W]
//   req_ready_o      one-hot grant (combinational from req_valid_i and rr)
//   rsp_valid_o      one-cycle read-response strobe for the owning port
//   rsp_data_o       shared read data; holds its value between responses
//   clear_start_i    pulse: start zeroing the whole memory
//   clear_busy_o     high while the clear is running
module ram_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10,
    parameter int PORTS  = 4,
    parameter int RD_LAT = 1
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [PORTS-1:0]         req_valid_i,
    input  logic [PORTS-1:0]         req_write_i,
    input  logic [PORTS*ADDR_W-1:0]  req_addr_i,
    input  logic [PORTS*DATA_W-1:0]  req_data_i,
    output logic [PORTS-1:0]         req_ready_o,
    output logic [PORTS-1:0]         rsp_valid_o,
    output logic [DATA_W-1:0]        rsp_data_o,
    input  logic                     clear_start_i,
    output logic                     clear_busy_o
);
    localparam int GW    = $clog2(PORTS);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {IDLE, CLEAR} state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] cnt_q;
    logic [GW-1:0]     rr_q;

    logic [DATA_W-1:0] mem [DEPTH];

    // Arbiter: the first valid port at or after rr, wrapping modulo PORTS.
    logic [PORTS-1:0]  gnt;
    logic [GW-1:0]     gidx;
    logic [GW-1:0]     cand;
    logic              found;

    always_comb begin
        gnt   = '0;
        gidx  = '0;
        cand  = '0;
        found = 1'b0;
        // Gating on reset keeps the grant low while reset is held.
        if (state_q == IDLE && rst_ni) begin
            for (int i = 0; i < PORTS; i++) begin
                cand = GW'((int'(rr_q) + i) % PORTS);
                if (!found && req_valid_i[cand]) begin
                    found     = 1'b1;
                    gnt[cand] = 1'b1;
                    gidx      = cand;
                end
            end
        end
    end

    assign req_ready_o = gnt;

    logic              xfer, wr_xfer, rd_xfer;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

    assign xfer     = |gnt;
    assign wr_xfer  = xfer &  req_write_i[gidx];
    assign rd_xfer  = xfer & ~req_write_i[gidx];
    assign sel_addr = req_addr_i[int'(gidx)*ADDR_W +: ADDR_W];
    assign sel_data = req_data_i[int'(gidx)*DATA_W +: DATA_W];

    // RAM write port. The memory itself is not reset, so a reset during a
    // clear leaves the memory partly zeroed.
    always_ff @(posedge clk_i) begin
        if (state_q == CLEAR)
            mem[cnt_q] <= '0;
        else if (wr_xfer)
            mem[sel_addr] <= sel_data;
    end

    // Read path: stage 0 is the RAM output register. Each later stage adds one
    // cycle of latency. Data and tag advance only when a response moves, so
    // rsp_data_o holds between responses. Reset drops in-flight reads.
    logic [RD_LAT-1:0]             vld_q;
    logic [RD_LAT-1:0][GW-1:0]     tag_q;
    logic [RD_LAT-1:0][DATA_W-1:0] dat_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_q <= '0;
            tag_q <= '0;
            dat_q <= '0;
        end else begin
            vld_q[0] <= rd_xfer;
            if (rd_xfer) begin
                tag_q[0] <= gidx;
                dat_q[0] <= mem[sel_addr];
            end
            for (int s = 1; s < RD_LAT; s++) begin
                vld_q[s] <= vld_q[s-1];
                if (vld_q[s-1]) begin
                    tag_q[s] <= tag_q[s-1];
                    dat_q[s] <= dat_q[s-1];
                end
            end
        end
    end

    assign rsp_valid_o = vld_q[RD_LAT-1] ? (PORTS'(1) << tag_q[RD_LAT-1]) : '0;
    assign rsp_data_o  = dat_q[RD_LAT-1];

    // Control FSM. A request granted in the same cycle as clear_start_i is
    // still served. The clear then starts on the following cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rr_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (xfer)
                        rr_q <= (gidx == GW'(PORTS-1)) ? '0 : gidx + 1'b1;
                    if (clear_start_i) begin
                        state_q <= CLEAR;
                        cnt_q   <= '0;
                    end
                end
                CLEAR: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == '1)
                        state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign clear_busy_o = (state_q == CLEAR);

endmodule

// File: tb/tb_ram_arbiter.sv
// Testbench for ram_arbiter. Two DUTs, one with RD_LAT=1 and one with
// RD_LAT=2, receive the same stimulus. A cycle-level reference model
// (round-robin grant rule, array memory, scheduled response events) checks
// both DUTs on every falling edge. Directed sequences and a grant table add
// explicit checks against constant expected values.
module tb_ram_arbiter;
    localparam int P = 4, AW = 10, DW = 32, DEPTH = 1024;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [P-1:0]    valid, wr;
    logic [P*AW-1:0] addr;
    logic [P*DW-1:0] data;
    logic            clr_start;
    logic [P-1:0]    rdy1, rdy2, rv1, rv2;
    logic [DW-1:0]   rd1, rd2;
    logic            busy1, busy2;

    ram_arbiter #(.DATA_W(DW), .ADDR_W(AW), .PORTS(P), .RD_LAT(1)) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .req_valid_i(valid), .req_write_i(wr),
        .req_addr_i(addr), .req_data_i(data), .req_ready_o(rdy1),
        .rsp_valid_o(rv1), .rsp_data_o(rd1), .clear_start_i(clr_start),
        .clear_busy_o(busy1));

    ram_arbiter #(.DATA_W(DW), .ADDR_W(AW), .PORTS(P), .RD_LAT(2)) dut2 (
        .clk_i(clk), .rst_ni(rst_n), .req_valid_i(valid), .req_write_i(wr),
        .req_addr_i(addr), .req_data_i(data), .req_ready_o(rdy2),
        .rsp_valid_o(rv2), .rsp_data_o(rd2), .clear_start_i(clr_start),
        .clear_busy_o(busy2));

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {int due; int port; logic [31:0] d; bit known;} rsp_t;
    rsp_t        q [2][$];
    logic [31:0] m_mem [DEPTH];
    bit          m_known [DEPTH];
    logic [31:0] lastd [2];
    bit          lk [2];
    int          cyc = 0, m_rr = 0, m_cnt = 0;
    bit          m_busy = 0;

    always @(negedge clk) begin : model
        logic [P-1:0]  eg;
        logic [P-1:0]  av;
        logic [31:0]   ad;
        int            g, a;
        rsp_t          e;
        cyc++;
        if (!rst_n) begin
            m_rr = 0; m_busy = 0; m_cnt = 0;
            for (int l = 0; l < 2; l++) begin
                q[l].delete(); lastd[l] = '0; lk[l] = 1;
            end
            chk("rst_ready1", rdy1, 0); chk("rst_ready2", rdy2, 0);
            chk("rst_rv1", rv1, 0);     chk("rst_rv2", rv2, 0);
            chk("rst_rd1", rd1, 0);     chk("rst_rd2", rd2, 0);
            chk("rst_busy1", busy1, 0); chk("rst_busy2", busy2, 0);
        end else begin
            eg = '0; g = -1;
            if (!m_busy)
                for (int i = 0; i < P; i++) begin
                    int c;
                    c = (m_rr + i) % P;
                    if (g < 0 && valid[c]) g = c;
                end
            if (g >= 0) eg[g] = 1'b1;
            chk("m_ready1", rdy1, eg); chk("m_ready2", rdy2, eg);
            chk("m_busy1", busy1, m_busy); chk("m_busy2", busy2, m_busy);
            for (int l = 0; l < 2; l++) begin
                av = (l == 0) ? rv1 : rv2;
                ad = (l == 0) ? rd1 : rd2;
                if (q[l].size() > 0 && q[l][0].due == cyc) begin
                    e = q[l].pop_front();
                    chk($sformatf("m_rsp_valid_L%0d", l+1), av, 4'b1 << e.port);
                    if (e.known) chk($sformatf("m_rsp_data_L%0d", l+1), ad, e.d);
                    lastd[l] = e.d; lk[l] = e.known;
                end else begin
                    chk($sformatf("m_rsp_idle_L%0d", l+1), av, 0);
                    if (lk[l]) chk($sformatf("m_rsp_hold_L%0d", l+1), ad, lastd[l]);
                end
            end
            // advance model across the coming rising edge
            if (m_busy) begin
                m_mem[m_cnt] = '0; m_known[m_cnt] = 1;
                if (m_cnt == DEPTH-1) m_busy = 0; else m_cnt++;
            end else begin
                if (g >= 0) begin
                    a = int'(addr[g*AW +: AW]);
                    if (wr[g]) begin
                        m_mem[a] = data[g*DW +: DW]; m_known[a] = 1;
                    end else begin
                        for (int l = 0; l < 2; l++) begin
                            e.due = cyc + l + 1; e.port = g;
                            e.d = m_mem[a]; e.known = m_known[a];
                            q[l].push_back(e);
                        end
                    end
                    m_rr = (g + 1) % P;
                end
                if (clr_start) begin m_busy = 1; m_cnt = 0; end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic idle();
        valid = '0; wr = '0; clr_start = 1'b0;
    endtask

    task automatic drive(input int p, input bit w, input int a, input logic [31:0] d);
        valid[p] = 1'b1; wr[p] = w;
        addr[p*AW +: AW] = AW'(a);
        data[p*DW +: DW] = d;
    endtask

    task automatic write1(input int a, input logic [31:0] d);
        drive(0, 1, a, d); tick(); idle();
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy1 && n < 2000) begin tick(); n++; end
        chk("clear_done", busy1, 0);
    endtask

    typedef struct {logic [3:0] v; logic [3:0] exp;} rr_vec_t;
    rr_vec_t tbl [14];

    initial begin : main
        int n;
        tbl[0]  = '{4'hF, 4'h1}; tbl[1]  = '{4'hF, 4'h2};
        tbl[2]  = '{4'hF, 4'h4}; tbl[3]  = '{4'hF, 4'h8};
        tbl[4]  = '{4'hF, 4'h1}; tbl[5]  = '{4'hF, 4'h2};
        tbl[6]  = '{4'hF, 4'h4}; tbl[7]  = '{4'hF, 4'h8};
        tbl[8]  = '{4'hF, 4'h1}; tbl[9]  = '{4'hF, 4'h2};
        tbl[10] = '{4'hA, 4'h8}; tbl[11] = '{4'hA, 4'h2};
        tbl[12] = '{4'h0, 4'h0}; tbl[13] = '{4'h4, 4'h4};

        idle(); addr = '0; data = '0; rst_n = 1'b0;
        // reset held with random inputs
        repeat (4) begin
            valid = P'($urandom); wr = P'($urandom);
            addr = {$urandom, $urandom};
            data = {$urandom, $urandom, $urandom, $urandom};
            clr_start = 1'($urandom);
            #1;
            chk("reset_ready", rdy1, 0); chk("reset_rv", rv2, 0);
            chk("reset_busy", busy1, 0); chk("reset_rdata", rd1, 0);
            tick();
        end
        idle(); tick(); rst_n = 1'b1; tick();

        // first write then read
        write1(5, 32'hDEADBEEF);
        drive(0, 0, 5, 0); tick(); idle();
        chk("t1_rv_L1", rv1, 4'b0001); chk("t1_rd_L1", rd1, 32'hDEADBEEF);
        chk("t1_rv_L2_early", rv2, 0);
        tick();
        chk("t1_rv_L2", rv2, 4'b0001); chk("t1_rd_L2", rd2, 32'hDEADBEEF);
        chk("t1_rv_L1_done", rv1, 0);

        // round-robin table, starting from rr = 0
        rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
        for (int p = 0; p < P; p++) addr[p*AW +: AW] = AW'(5);
        for (int i = 0; i < 14; i++) begin
            valid = tbl[i].v; wr = '0;
            #1;
            chk($sformatf("rr_tbl%0d_L1", i), rdy1, tbl[i].exp);
            chk($sformatf("rr_tbl%0d_L2", i), rdy2, tbl[i].exp);
            tick();
        end
        idle(); tick(); tick();

        // latency / ordering
        write1('h20, 32'h11); write1('h21, 32'h22); write1('h22, 32'h33);
        drive(2, 0, 'h20, 0); tick(); idle();
        chk("ord_rv1_a", rv1, 4'b0100); chk("ord_rd1_a", rd1, 32'h11);
        drive(0, 0, 'h21, 0); tick(); idle();
        chk("ord_rv1_b", rv1, 4'b0001); chk("ord_rd1_b", rd1, 32'h22);
        chk("ord_rv2_a", rv2, 4'b0100); chk("ord_rd2_a", rd2, 32'h11);
        drive(1, 0, 'h22, 0); tick(); idle();
        chk("ord_rv1_c", rv1, 4'b0010); chk("ord_rd1_c", rd1, 32'h33);
        chk("ord_rv2_b", rv2, 4'b0001); chk("ord_rd2_b", rd2, 32'h22);
        tick();
        chk("ord_rv1_end", rv1, 0);     chk("ord_rd1_hold", rd1, 32'h33);
        chk("ord_rv2_c", rv2, 4'b0010); chk("ord_rd2_c", rd2, 32'h33);
        tick();
        chk("ord_rv2_end", rv2, 0);

        // bulk clear with all ports requesting and a second start mid-clear
        for (int a = 0; a < 16; a++) write1(a, 32'hFFFFFFFF);
        clr_start = 1'b1; tick(); clr_start = 1'b0;
        chk("clr_rise", busy1, 1);
        valid = 4'hF; wr = '0;
        for (int p = 0; p < P; p++) addr[p*AW +: AW] = AW'('h00A);
        n = 0;
        while (busy1 && n < 2000) begin
            n++;
            chk("clr_ready", rdy1, 0);
            clr_start = (n == 500);
            tick();
        end
        clr_start = 1'b0;
        chk("clr_len", n, 1024);
        chk("post_clr_ready", rdy1, 4'b0010);
        tick(); idle();
        chk("post_clr_rv", rv1, 4'b0010); chk("post_clr_rd", rd1, 0);
        tick(); tick();

        // read granted in the same cycle as clear_start
        write1('h30, 32'h55);
        drive(1, 0, 'h30, 0); clr_start = 1'b1; tick(); idle();
        chk("ovl_rv1", rv1, 4'b0010); chk("ovl_rd1", rd1, 32'h55);
        chk("ovl_busy", busy1, 1);
        tick();
        chk("ovl_rv2", rv2, 4'b0010); chk("ovl_rd2", rd2, 32'h55);
        wait_idle();
        tick();

        // reset with a read in flight
        drive(3, 0, 5, 0); tick(); idle();
        rst_n = 1'b0; #1;
        chk("rstf_rv2", rv2, 0);
        tick(); rst_n = 1'b1;
        repeat (3) begin
            tick();
            chk("rstf_rv1_after", rv1, 0); chk("rstf_rv2_after", rv2, 0);
        end

        // reset at clear cycle 100
        write1(200, 32'hA5A5A5A5); write1(50, 32'hC3C3C3C3);
        clr_start = 1'b1; tick(); idle();
        repeat (100) tick();
        rst_n = 1'b0; #1;
        chk("rstc_busy", busy1, 0);
        tick(); rst_n = 1'b1; tick();
        drive(0, 0, 200, 0); tick(); idle();
        chk("rstc_keep", rd1, 32'hA5A5A5A5);
        drive(0, 0, 50, 0); tick(); idle();
        chk("rstc_zeroed", rd1, 0);
        tick(); tick();

        // random traffic against the model
        repeat (400) begin
            valid = P'($urandom); wr = P'($urandom);
            for (int p = 0; p < P; p++) begin
                addr[p*AW +: AW] = AW'($urandom_range(0, 31));
                data[p*DW +: DW] = $urandom;
            end
            tick();
        end
        idle(); repeat (4) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Parametrised multi-port successor to the single-port block-RAM access wrapper in the neural-network datapath. Holds one inferred single-port RAM of 2^ADDR_W words and serves PORTS independent requesters (weight loader, neuron evaluators, host) through valid/ready handshakes with round-robin arbitration. Returns read data with a per-port response strobe after a fixed latency, and provides a hardware bulk-clear mode that zeroes the whole memory between training passes.

## Interface
- DATA_W, 32, word width
- ADDR_W, 10, address width; depth = 2^ADDR_W
- PORTS, 4, number of requesters (2..8)
- RD_LAT, 1, read latency in cycles from handshake to response (legal: 1 or 2)

- CLOCK  in  1  single clock, all logic rising-edge
- RESETN  in  1  asynchronous, active-low reset
- req_valid  in  PORTS  per-port request present
- req_write  in  PORTS  per-port 1 = write, 0 = read
- req_addr  in  PORTS*ADDR_W  port p at bits [p*ADDR_W +: ADDR_W]
- req_data  in  PORTS*DATA_W  write data, port p at [p*DATA_W +: DATA_W]
- req_ready  out  PORTS  one-hot grant; transfer when req_valid[p] && req_ready[p]
- rsp_valid  out  PORTS  one-cycle strobe: read data for port p on rsp_data
- rsp_data  out  DATA_W  shared read-data bus
- clear_start  in  1  pulse: begin zeroing entire memory
- clear_busy  out  1  high while clear in progress

## Operation
- States: IDLE, CLEAR. Reset -> IDLE.
- IDLE: at most one access per cycle. Grant goes to the first port with req_valid=1, searching from pointer rr upward, modulo PORTS. req_ready is combinational from req_valid and rr. It is one-hot or all-zero, and never asserted to a port with req_valid=0.
- On a transfer by port g: rr <= (g+1) mod PORTS. If there is no transfer, rr holds.
- Write transfer: mem[addr] <= data at that edge. There is no response for writes.
- Read transfer: mem[addr] is read. Port index g travels with the read through a RD_LAT-deep tag pipeline.
- A write followed by a read of the same address on the next cycle returns the new data. Because accesses are one per cycle, there are no same-cycle collisions.
- Requesters hold addr, data and write stable while valid and not ready. The block does not check this.
- clear_start in IDLE: enter CLEAR next cycle with counter = 0 and clear_busy = 1.
- CLEAR state:
  - Write 0 to mem[counter] each cycle, counter +1.
  - When counter = 2^ADDR_W-1 is written, return to IDLE and drop clear_busy.
  - A clear takes exactly 2^ADDR_W cycles. req_ready is all-zero throughout.
- clear_start during CLEAR is ignored. clear_start and a req_valid in the same IDLE cycle: the request is still granted that cycle, and CLEAR begins next cycle.
- Reads already in the tag pipeline when CLEAR starts still complete with pre-clear data.
- Reset values: req_ready 0 (all ports), rsp_valid 0, rsp_data 0, clear_busy 0, rr 0, counter 0, state IDLE.
- Memory contents are not reset.
- RESETN asserted mid-operation:
  - In-flight reads are dropped, with no rsp_valid.
  - A partial clear is abandoned, leaving the memory partly zeroed.

## Timing
- Throughput: one access per cycle in IDLE.
- RD_LAT=1: handshake at edge N; rsp_valid[g] and rsp_data valid for the cycle after edge N (synchronous RAM output register).
- RD_LAT=2: an extra output register on both data and tag; response one cycle later than RD_LAT=1.
- Back-to-back reads from different ports produce back-to-back responses in grant order. rsp_valid is one-hot or zero every cycle.
- rsp_data holds its last value when rsp_valid = 0.
- clear_busy rises the cycle after clear_start is sampled. It falls the cycle after the last zero write, and req_ready may assert in that same cycle.

## Test plan
- Reset: hold RESETN=0 with random inputs -> req_ready=0, rsp_valid=0, rsp_data=0, clear_busy=0. Release, then port 0 writes 0xDEADBEEF to 0x005 and reads it -> rsp_valid[0] after RD_LAT cycles, rsp_data=0xDEADBEEF.
- Round-robin: all 4 ports hold reads for 8 cycles -> grants 0,1,2,3,0,1,2,3. Only ports 1 and 3 valid after a grant to 1 -> next grant is 3.
- Latency/ordering: ports 2,0,1 issue reads on consecutive cycles to addresses holding 0x11,0x22,0x33 -> rsp_valid sequence 2,0,1 at RD_LAT offsets with matching data. Repeat with RD_LAT=2.
- Clear: fill addresses 0..15 with 0xFFFFFFFF, pulse clear_start -> clear_busy high for exactly 1024 cycles and req_ready=0 throughout. Afterwards, reading 0x00A returns 0. A second clear_start mid-clear does not extend clear_busy.
- Clear overlap: a read granted in the same cycle as clear_start to an address holding 0x55 -> response 0x55 after RD_LAT cycles, then the clear proceeds.
- Reset mid-flight: a read handshake followed by RESETN=0 before RD_LAT elapses -> no rsp_valid after release. Reset at clear cycle 100 -> clear_busy=0, IDLE, and addresses ≥100 keep their old data.
